// File: rtl/traffic_light_monitor.sv
// Passive safety checker for a two-road traffic light bus: decodes phases and flags conflict, encoding, sequence and dwell errors.
// Stage 1 registers the decoded sample and stage 2 registers the checks; it drives nothing back into the controller.

module traffic_light_road #(
    parameter int GREEN_MIN  = 11,
    parameter int GREEN_MAX  = 11,
    parameter int YELLOW_MIN = 6,
    parameter int YELLOW_MAX = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light,
    output logic [1:0] phase,
    output logic       enc_err,
    output logic       seq_err,
    output logic       tim_err
);
    localparam logic [1:0] PH_R = 2'b00;
    localparam logic [1:0] PH_G = 2'b01;
    localparam logic [1:0] PH_Y = 2'b10;
    localparam logic [1:0] PH_X = 2'b11;
    localparam logic [7:0] G_MIN = 8'(GREEN_MIN);
    localparam logic [7:0] G_MAX = 8'(GREEN_MAX);
    localparam logic [7:0] Y_MIN = 8'(YELLOW_MIN);
    localparam logic [7:0] Y_MAX = 8'(YELLOW_MAX);

    logic       enc_q;
    logic       hist_vld;
    logic       first_ph;
    logic [1:0] hist_ph;
    logic [7:0] dwell;
    logic [1:0] dec;
    logic       legal;
    logic [1:0] succ;
    logic       change;
    logic       in_gy;
    logic [7:0] min_v;
    logic [7:0] max_v;

    // An illegal code holds the previous phase, so it never looks like a transition.
    always_comb begin
        dec   = phase;
        legal = 1'b1;
        case (light)
            3'b001:  dec = PH_G;
            3'b010:  dec = PH_Y;
            3'b100:  dec = PH_R;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= PH_X;
            enc_q <= 1'b0;
        end else begin
            phase <= dec;
            enc_q <= ~legal;
        end
    end

    always_comb begin
        succ = PH_X;
        case (hist_ph)
            PH_G:    succ = PH_Y;
            PH_Y:    succ = PH_R;
            PH_R:    succ = PH_G;
            default: succ = PH_X;
        endcase
        change  = hist_vld && (phase != hist_ph);
        in_gy   = (hist_ph == PH_G) || (hist_ph == PH_Y);
        min_v   = (hist_ph == PH_G) ? G_MIN : Y_MIN;
        max_v   = (hist_ph == PH_G) ? G_MAX : Y_MAX;
        enc_err = enc_q;
        seq_err = change && (phase != succ);
        // Overrun fires once, when the stored dwell sits at MAX and the phase continues.
        tim_err = in_gy && ((change && !first_ph && (dwell < min_v)) ||
                            (hist_vld && !change && (dwell == max_v)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_vld <= 1'b0;
            hist_ph  <= PH_X;
            dwell    <= 8'd0;
            first_ph <= 1'b1;
        end else if (!hist_vld) begin
            if (phase != PH_X) begin
                hist_vld <= 1'b1;
                hist_ph  <= phase;
                dwell    <= 8'd1;
            end
        end else if (change) begin
            hist_ph  <= phase;
            dwell    <= 8'd1;
            first_ph <= 1'b0;
        end else if (dwell != 8'hFF) begin
            dwell <= dwell + 8'd1;
        end
    end
endmodule

module traffic_light_monitor #(
    parameter int GREEN_MIN  = 11,
    parameter int GREEN_MAX  = 11,
    parameter int YELLOW_MIN = 6,
    parameter int YELLOW_MAX = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_a,
    input  logic [2:0] light_b,
    input  logic       clr,
    output logic [1:0] phase_a,
    output logic [1:0] phase_b,
    output logic       err_conflict,
    output logic       err_encoding,
    output logic       err_sequence,
    output logic       err_timing,
    output logic       error_sticky,
    output logic [7:0] err_count
);
    logic enc_a, seq_a, tim_a;
    logic enc_b, seq_b, tim_b;
    logic conflict_nxt;
    logic any_nxt;

    traffic_light_road #(
        .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
        .YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX)
    ) u_road_a (
        .clk(clk), .rst(rst), .light(light_a), .phase(phase_a),
        .enc_err(enc_a), .seq_err(seq_a), .tim_err(tim_a)
    );

    traffic_light_road #(
        .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
        .YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX)
    ) u_road_b (
        .clk(clk), .rst(rst), .light(light_b), .phase(phase_b),
        .enc_err(enc_b), .seq_err(seq_b), .tim_err(tim_b)
    );

    always_comb begin
        conflict_nxt = (phase_a != 2'b11) && (phase_b != 2'b11) &&
                       (phase_a != 2'b00) && (phase_b != 2'b00);
        any_nxt      = conflict_nxt | enc_a | enc_b | seq_a | seq_b | tim_a | tim_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_conflict <= 1'b0;
            err_encoding <= 1'b0;
            err_sequence <= 1'b0;
            err_timing   <= 1'b0;
            error_sticky <= 1'b0;
            err_count    <= 8'd0;
        end else begin
            err_conflict <= conflict_nxt;
            err_encoding <= enc_a | enc_b;
            err_sequence <= seq_a | seq_b;
            err_timing   <= tim_a | tim_b;
            if (clr) begin
                error_sticky <= 1'b0;
                err_count    <= 8'd0;
            end else if (any_nxt) begin
                error_sticky <= 1'b1;
                if (err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: each sample carries its hand-computed error vector {conflict,encoding,sequence,timing},
// checked two edges later.
module tb_traffic_light_monitor;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [2:0] light_a = R;
    logic [2:0] light_b = R;
    logic [1:0] phase_a, phase_b;
    logic       err_conflict, err_encoding, err_sequence, err_timing, error_sticky;
    logic [7:0] err_count;

    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] pend = 4'b0000;

    traffic_light_monitor dut (
        .clk(clk), .rst(rst), .light_a(light_a), .light_b(light_b), .clr(clr),
        .phase_a(phase_a), .phase_b(phase_b),
        .err_conflict(err_conflict), .err_encoding(err_encoding),
        .err_sequence(err_sequence), .err_timing(err_timing),
        .error_sticky(error_sticky), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] dec(input logic [2:0] l);
        case (l)
            G:       dec = 2'b01;
            Y:       dec = 2'b10;
            R:       dec = 2'b00;
            default: dec = 2'b11;
        endcase
    endfunction

    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic [3:0] e);
        light_a = a;
        light_b = b;
        @(posedge clk);
        #1;
        chk("err_vec", {4'b0, err_conflict, err_encoding, err_sequence, err_timing}, {4'b0, pend});
        pend = e;
    endtask

    task automatic hold(input logic [2:0] a, input logic [2:0] b, input int n);
        for (int i = 0; i < n; i++) step(a, b, 4'b0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pend = 4'b0000;
        chk("rst_phase", {4'b0, phase_a, phase_b}, 8'h0F);
        chk("rst_err", {4'b0, err_conflict, err_encoding, err_sequence, err_timing}, 8'h00);
        chk("rst_sticky", {7'b0, error_sticky}, 8'h00);
        chk("rst_count", err_count, 8'h00);
    endtask

    logic [2:0] a, b;
    logic [3:0] e;

    initial begin
        light_a = R;
        light_b = R;
        @(posedge clk);
        #1;
        do_reset();

        // Three legal rounds; B turns green on the edge A turns red.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 34; i++) begin
                a = (i < 11) ? G : (i < 17) ? Y : R;
                b = (i < 17) ? R : (i < 28) ? G : Y;
                step(a, b, 4'b0000);
                chk("phase_a", {6'b0, phase_a}, {6'b0, dec(a)});
                chk("phase_b", {6'b0, phase_b}, {6'b0, dec(b)});
            end
        end
        chk("legal_count", err_count, 8'd0);
        chk("legal_sticky", {7'b0, error_sticky}, 8'h00);

        // Conflict at i=5, B's 1-cycle green drops to red at i=6, encoding glitch on A at i=7.
        for (int i = 0; i < 34; i++) begin
            a = (i < 11) ? G : (i < 17) ? Y : R;
            b = (i < 17) ? R : (i < 28) ? G : Y;
            e = 4'b0000;
            if (i == 5) begin b = G; e = 4'b1000; end
            if (i == 6) e = 4'b0011;
            if (i == 7) begin a = 3'b011; e = 4'b0100; end
            step(a, b, e);
            if (i == 6) begin
                chk("conf_count", err_count, 8'd1);
                chk("conf_sticky", {7'b0, error_sticky}, 8'h01);
            end
            if (i == 7) begin
                chk("enc_phase_hold", {6'b0, phase_a}, 8'h01);
                chk("seqtim_count", err_count, 8'd2);
            end
            if (i == 8) chk("enc_count", err_count, 8'd3);
        end
        chk("round_count", err_count, 8'd3);

        // Sequence errors: A G->R after full green, later R->Y; B parked on red.
        clr = 1'b1;
        step(G, R, 4'b0000);
        clr = 1'b0;
        chk("clr_count", err_count, 8'd0);
        chk("clr_sticky", {7'b0, error_sticky}, 8'h00);
        hold(G, R, 10);
        step(R, R, 4'b0010);
        hold(R, R, 2);
        step(Y, R, 4'b0010);
        chk("seq_count1", err_count, 8'd1);
        hold(Y, R, 1);
        chk("seq_count2", err_count, 8'd2);
        hold(Y, R, 4);
        hold(R, R, 3);
        chk("seq_after", err_count, 8'd2);

        // Short green (9) ends early; long green (15) overruns once at dwell 12.
        hold(G, R, 9);
        step(Y, R, 4'b0001);
        hold(Y, R, 5);
        hold(R, R, 2);
        chk("short_green", err_count, 8'd3);
        hold(G, R, 11);
        step(G, R, 4'b0001);
        hold(G, R, 3);
        hold(Y, R, 6);
        hold(R, R, 2);
        chk("long_green", err_count, 8'd4);

        // Partial first green after reset, then reset mid-yellow and resume on yellow.
        do_reset();
        hold(G, R, 4);
        hold(Y, R, 6);
        hold(R, R, 3);
        hold(G, R, 11);
        hold(Y, R, 3);
        do_reset();
        hold(Y, R, 4);
        hold(R, R, 3);
        chk("resume_count", err_count, 8'd0);
        chk("resume_sticky", {7'b0, error_sticky}, 8'h00);

        // 300 conflicting samples saturate the counter; both roads overrun together at dwell 12.
        for (int i = 0; i < 300; i++)
            step(G, G, (i == 11) ? 4'b1001 : 4'b1000);
        chk("sat_count", err_count, 8'd255);
        chk("sat_sticky", {7'b0, error_sticky}, 8'h01);
        clr = 1'b1;
        step(G, G, 4'b1000);
        clr = 1'b0;
        chk("clr_beats_count", err_count, 8'd0);
        chk("clr_beats_sticky", {7'b0, error_sticky}, 8'h00);
        step(G, G, 4'b1000);
        chk("post_clr_count", err_count, 8'd1);
        chk("post_clr_sticky", {7'b0, error_sticky}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
